// File: rtl/axis_multi_comparator.sv
`default_nettype none
// ============================================================================
// Module   : axis_multi_comparator
// Brief    : Joins N AXI-Stream inputs beat by beat and compares streams 1..N-1
//            against stream 0 within a signed tolerance; reports a final verdict.
// Revision : 1.0 - initial release
// ============================================================================
module axis_multi_comparator #(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_STREAMS      = 4,
    parameter int TOLERANCE        = 0,
    parameter int STOP_ON_MISMATCH = 1,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_STREAMS-1:0]               s_valid,
    output logic [NUM_STREAMS-1:0]               s_ready,
    input  logic [NUM_STREAMS-1:0]               s_last,
    input  logic [NUM_STREAMS*DATA_WIDTH-1:0]    s_data,
    input  logic                                 clear,
    output logic [2:0]                           result,
    output logic                                 done,
    output logic [CNT_WIDTH-1:0]                 beat_count,
    output logic [CNT_WIDTH-1:0]                 mismatch_count,
    output logic [CNT_WIDTH-1:0]                 first_mismatch_index,
    output logic [((NUM_STREAMS > 2) ? $clog2(NUM_STREAMS) : 1)-1:0] first_mismatch_channel
);

    localparam int CH_W = (NUM_STREAMS > 2) ? $clog2(NUM_STREAMS) : 1;
    localparam int DW1  = DATA_WIDTH + 1;
    localparam logic [DATA_WIDTH:0] c_tol = DW1'(TOLERANCE);

    typedef enum logic [1:0] {
        S_RUN           = 2'd0,
        S_DONE_EQUAL    = 2'd1,
        S_DONE_MISMATCH = 2'd2,
        S_DONE_LENGTH   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_beat_cnt;
    logic [CNT_WIDTH-1:0]   r_mis_cnt;
    logic [CNT_WIDTH-1:0]   r_first_idx;
    logic [CH_W-1:0]        r_first_ch;

    logic                   w_accept;
    logic [NUM_STREAMS-1:0] w_mis;
    logic                   w_beat_mis;
    logic                   w_len_err;
    logic                   w_all_last;
    logic [CH_W-1:0]        w_first_ch;

    assign w_accept   = (r_state == S_RUN) && !clear && (&s_valid);
    assign s_ready    = {NUM_STREAMS{w_accept}};
    assign w_beat_mis = |w_mis;
    assign w_len_err  = (|s_last) && !(&s_last);
    assign w_all_last = &s_last;

    // Sign-extend by one bit so the difference of two extreme values cannot overflow.
    generate
        for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_chan
            if (gi == 0) begin : g_ref
                assign w_mis[gi] = 1'b0;
            end else begin : g_cmp
                logic [DATA_WIDTH-1:0] w_ref;
                logic [DATA_WIDTH-1:0] w_dat;
                logic signed [DATA_WIDTH:0] w_diff;
                logic [DATA_WIDTH:0]   w_abs;
                assign w_ref  = s_data[0 +: DATA_WIDTH];
                assign w_dat  = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
                assign w_diff = $signed({w_dat[DATA_WIDTH-1], w_dat})
                              - $signed({w_ref[DATA_WIDTH-1], w_ref});
                assign w_abs  = w_diff[DATA_WIDTH] ? DW1'(-w_diff) : DW1'(w_diff);
                assign w_mis[gi] = (w_abs > c_tol);
            end
        end
    endgenerate

    // Scan from the top down so the lowest failing channel wins.
    always_comb begin
        w_first_ch = '0;
        for (int i = NUM_STREAMS - 1; i >= 1; i--) begin
            if (w_mis[i]) begin
                w_first_ch = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_RUN;
        end else if (w_accept) begin
            if (STOP_ON_MISMATCH != 0) begin
                if (w_beat_mis)      w_state_nxt = S_DONE_MISMATCH;
                else if (w_len_err)  w_state_nxt = S_DONE_LENGTH;
                else if (w_all_last) w_state_nxt = S_DONE_EQUAL;
            end else begin
                if (w_len_err) begin
                    w_state_nxt = S_DONE_LENGTH;
                end else if (w_all_last) begin
                    w_state_nxt = ((r_mis_cnt != '0) || w_beat_mis) ? S_DONE_MISMATCH
                                                                    : S_DONE_EQUAL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= S_RUN;
            r_beat_cnt  <= '0;
            r_mis_cnt   <= '0;
            r_first_idx <= '0;
            r_first_ch  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (r_beat_cnt != '1) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
                if (w_beat_mis) begin
                    if (r_mis_cnt != '1) begin
                        r_mis_cnt <= r_mis_cnt + 1'b1;
                    end
                    // A saturating count never returns to zero, so zero means "first".
                    if (r_mis_cnt == '0) begin
                        r_first_idx <= r_beat_cnt;
                        r_first_ch  <= w_first_ch;
                    end
                end
            end
        end
    end

    always_comb begin
        result = 3'b000;
        case (r_state)
            S_DONE_EQUAL:    result = 3'b001;
            S_DONE_MISMATCH: result = 3'b010;
            S_DONE_LENGTH:   result = 3'b100;
            default:         result = 3'b000;
        endcase
    end

    assign done                   = (r_state != S_RUN);
    assign beat_count             = r_beat_cnt;
    assign mismatch_count         = r_mis_cnt;
    assign first_mismatch_index   = r_first_idx;
    assign first_mismatch_channel = r_first_ch;

endmodule
`default_nettype wire

// File: tb/tb_axis_multi_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_multi_comparator
// Brief    : Directed table-driven bench for axis_multi_comparator over four
//            parameterisations sharing one stimulus bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_multi_comparator;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic [N-1:0]   s_valid;
    logic [N-1:0]   s_last;
    logic [N*W-1:0] s_data;

    always #5 clk = ~clk;

    logic [N-1:0] rdy_a, rdy_b, rdy_c, rdy_d;
    logic [2:0]   res_a, res_b, res_c, res_d;
    logic         done_a, done_b, done_c, done_d;
    logic [15:0]  bc_a, bc_b, bc_c, mc_a, mc_b, mc_c, fi_a, fi_b, fi_c;
    logic [2:0]   bc_d, mc_d, fi_d;
    logic [1:0]   fc_a, fc_b, fc_c, fc_d;

    // a: exact/stop, b: tolerance 2/stop, c: exact/run-to-end, d: 3-bit counters
    axis_multi_comparator #(.DATA_WIDTH(W), .NUM_STREAMS(N), .TOLERANCE(0),
        .STOP_ON_MISMATCH(1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy_a), .s_last(s_last),
        .s_data(s_data), .clear(clear), .result(res_a), .done(done_a),
        .beat_count(bc_a), .mismatch_count(mc_a), .first_mismatch_index(fi_a),
        .first_mismatch_channel(fc_a));
    axis_multi_comparator #(.DATA_WIDTH(W), .NUM_STREAMS(N), .TOLERANCE(2),
        .STOP_ON_MISMATCH(1), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy_b), .s_last(s_last),
        .s_data(s_data), .clear(clear), .result(res_b), .done(done_b),
        .beat_count(bc_b), .mismatch_count(mc_b), .first_mismatch_index(fi_b),
        .first_mismatch_channel(fc_b));
    axis_multi_comparator #(.DATA_WIDTH(W), .NUM_STREAMS(N), .TOLERANCE(0),
        .STOP_ON_MISMATCH(0), .CNT_WIDTH(16)) dut_c (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy_c), .s_last(s_last),
        .s_data(s_data), .clear(clear), .result(res_c), .done(done_c),
        .beat_count(bc_c), .mismatch_count(mc_c), .first_mismatch_index(fi_c),
        .first_mismatch_channel(fc_c));
    axis_multi_comparator #(.DATA_WIDTH(W), .NUM_STREAMS(N), .TOLERANCE(0),
        .STOP_ON_MISMATCH(1), .CNT_WIDTH(3)) dut_d (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy_d), .s_last(s_last),
        .s_data(s_data), .clear(clear), .result(res_d), .done(done_d),
        .beat_count(bc_d), .mismatch_count(mc_d), .first_mismatch_index(fi_d),
        .first_mismatch_channel(fc_d));

    logic [1:0]   sel;
    logic [N-1:0] t_rdy;
    logic [2:0]   t_res;
    logic         t_done;
    logic [15:0]  t_bc, t_mc, t_fi;
    logic [1:0]   t_fc;

    always_comb begin
        t_rdy = rdy_a; t_res = res_a; t_done = done_a;
        t_bc = bc_a; t_mc = mc_a; t_fi = fi_a; t_fc = fc_a;
        case (sel)
            2'd1: begin
                t_rdy = rdy_b; t_res = res_b; t_done = done_b;
                t_bc = bc_b; t_mc = mc_b; t_fi = fi_b; t_fc = fc_b;
            end
            2'd2: begin
                t_rdy = rdy_c; t_res = res_c; t_done = done_c;
                t_bc = bc_c; t_mc = mc_c; t_fi = fi_c; t_fc = fc_c;
            end
            2'd3: begin
                t_rdy = rdy_d; t_res = res_d; t_done = done_d;
                t_bc = {13'd0, bc_d}; t_mc = {13'd0, mc_d}; t_fi = {13'd0, fi_d}; t_fc = fc_d;
            end
            default: ;
        endcase
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, k, act, exp);
        end
    endtask

    // Packet description: every stream carries base+17*beat, plus optional offsets.
    typedef struct {
        int sel; int stall; int base;
        int l0; int l1; int l2; int l3;
        int d1all;
        int ms0; int mb0; int md0;
        int ms1; int mb1; int md1;
        int res; int bc; int mc; int fi; int fc;
    } vec_t;

    function automatic logic [W-1:0] beat_val(input vec_t v, input int s, input int b);
        int val;
        val = v.base + 17 * b;
        if (s == 1) val += v.d1all;
        if (v.ms0 == s && v.mb0 == b) val += v.md0;
        if (v.ms1 == s && v.mb1 == b) val += v.md1;
        return val[W-1:0];
    endfunction

    function automatic int len_of(input vec_t v, input int s);
        case (s)
            0: return v.l0;
            1: return v.l1;
            2: return v.l2;
            default: return v.l3;
        endcase
    endfunction

    task automatic clear_pulse();
        @(negedge clk);
        clear = 1'b1;
        s_valid = '0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic send_beat(input logic [N*W-1:0] d, input logic [N-1:0] l);
        @(negedge clk);
        s_data  = d;
        s_last  = l;
        s_valid = '1;
        @(negedge clk);
        s_valid = '0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int idx [N];
        logic [N-1:0] go;
        bit all_sent;
        int cyc;
        sel = 2'(v.sel);
        clear_pulse();
        check("clear_result", k, 32'(t_res), 32'd0);
        check("clear_beats", k, 32'(t_bc), 32'd0);
        check("clear_mism", k, 32'(t_mc), 32'd0);
        for (int i = 0; i < N; i++) idx[i] = 0;
        go = '0;
        for (cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            all_sent = 1'b1;
            for (int i = 0; i < N; i++) if (idx[i] < len_of(v, i)) all_sent = 1'b0;
            if (t_done || all_sent) break;
            for (int i = 0; i < N; i++) begin
                if (idx[i] >= len_of(v, i)) s_valid[i] = 1'b0;
                else if (v.stall == 0) s_valid[i] = 1'b1;
                else if (go[i] || !s_valid[i]) s_valid[i] = ($urandom_range(0, 2) != 0);
                s_data[i*W +: W] = beat_val(v, i, idx[i]);
                s_last[i] = (idx[i] == len_of(v, i) - 1);
            end
            #1;
            go = s_valid & t_rdy;
            @(posedge clk);
            for (int i = 0; i < N; i++) if (go[i]) idx[i]++;
        end
        s_valid = '0;
        if (cyc >= 200) check("timeout", k, 32'd1, 32'd0);
        check("result", k, 32'(t_res), 32'(v.res));
        check("done", k, 32'(t_done), 32'(v.res != 0));
        check("beat_count", k, 32'(t_bc), 32'(v.bc));
        check("mismatch_count", k, 32'(t_mc), 32'(v.mc));
        check("first_index", k, 32'(t_fi), 32'(v.fi));
        check("first_channel", k, 32'(t_fc), 32'(v.fc));
        s_valid = '1;
        #1;
        check("ready_after_done", k, 32'(t_rdy), 32'd0);
        @(negedge clk);
        check("frozen_beats", k, 32'(t_bc), 32'(v.bc));
        s_valid = '0;
    endtask

    vec_t vecs [14];

    initial begin
        //           sel stl base l0 l1 l2 l3 d1  ms0 mb0 md0  ms1 mb1 md1  res   bc mc fi fc
        vecs[0]  = '{0, 0, 5,   8, 8, 8, 8, 0,  -1, 0, 0,   -1, 0, 0,   1,    8, 0, 0, 0};
        vecs[1]  = '{0, 0, 5,   8, 8, 8, 8, 0,   2, 3, 1,   -1, 0, 0,   2,    4, 1, 3, 2};
        vecs[2]  = '{1, 0, 5,   5, 5, 5, 5, -2, -1, 0, 0,   -1, 0, 0,   1,    5, 0, 0, 0};
        vecs[3]  = '{1, 0, 5,   5, 5, 5, 5, 0,   1, 1, 3,   -1, 0, 0,   2,    2, 1, 1, 1};
        vecs[4]  = '{1, 0, 5,   5, 5, 5, 5, 0,   3, 2, 2,    2, 0, -2,  1,    5, 0, 0, 0};
        vecs[5]  = '{0, 0, 5,   7, 7, 7, 5, 0,  -1, 0, 0,   -1, 0, 0,   4,    5, 0, 0, 0};
        vecs[6]  = '{2, 0, 5,   8, 8, 8, 8, 0,   3, 1, 1,    1, 5, -1,  2,    8, 2, 1, 3};
        vecs[7]  = '{0, 1, 5,   6, 6, 6, 6, 0,  -1, 0, 0,   -1, 0, 0,   1,    6, 0, 0, 0};
        vecs[8]  = '{2, 1, 5,   4, 4, 4, 4, 0,   2, 2, 5,   -1, 0, 0,   2,    4, 1, 2, 2};
        vecs[9]  = '{0, 0, 5,   4, 4, 4, 3, 0,   1, 2, 1,   -1, 0, 0,   2,    3, 1, 2, 1};
        vecs[10] = '{2, 0, 5,   4, 4, 4, 3, 0,   1, 2, 1,   -1, 0, 0,   4,    3, 1, 2, 1};
        vecs[11] = '{0, 0, 5,   8, 8, 8, 8, 0,   3, 0, 1,    2, 0, 1,   2,    1, 1, 0, 2};
        vecs[12] = '{1, 0, 128, 1, 1, 1, 1, 0,   1, 0, -1,  -1, 0, 0,   2,    1, 1, 0, 1};
        vecs[13] = '{3, 0, 5,  10,10,10,10, 0,  -1, 0, 0,   -1, 0, 0,   1,    7, 0, 0, 0};

        rst = 1'b1; clear = 1'b0; s_valid = '0; s_last = '0; s_data = '0; sel = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_result", -1, 32'(t_res), 32'd0);
        check("rst_done", -1, 32'(t_done), 32'd0);
        check("rst_beats", -1, 32'(t_bc), 32'd0);
        check("rst_mism", -1, 32'(t_mc), 32'd0);
        check("rst_first", -1, {t_fi, 14'd0, t_fc}, 32'd0);
        s_valid = 4'b1011;
        #1;
        check("ready_partial", -1, 32'(t_rdy), 32'd0);
        s_valid = 4'b1111;
        #1;
        check("ready_join", -1, 32'(t_rdy), 32'hF);
        s_valid = '0;

        for (int k = 0; k < 14; k++) run_vec(k, vecs[k]);

        // A beat offered while clear is high must not be taken.
        sel = 2'd0;
        clear_pulse();
        @(negedge clk);
        clear = 1'b1; s_data = {4{8'h42}}; s_last = '1; s_valid = '1;
        #1;
        check("ready_in_clear", -1, 32'(t_rdy), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        check("clear_beat_dropped", -1, 32'(t_bc), 32'd0);
        check("clear_beat_result", -1, 32'(t_res), 32'd0);
        @(negedge clk);
        s_valid = '0;
        check("post_clear_result", -1, 32'(t_res), 32'd1);
        check("post_clear_beats", -1, 32'(t_bc), 32'd1);

        // Reset mid-packet: the tail is judged as a fresh packet.
        clear_pulse();
        for (int b = 0; b < 3; b++) send_beat({4{8'(b + 1)}}, 4'b0000);
        check("mid_beats", -1, 32'(t_bc), 32'd3);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_rst_beats", -1, 32'(t_bc), 32'd0);
        for (int b = 3; b < 8; b++) send_beat({4{8'(b + 1)}}, (b == 7) ? 4'b1111 : 4'b0000);
        check("tail_result", -1, 32'(t_res), 32'd1);
        check("tail_beats", -1, 32'(t_bc), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
